// File: rtl/ahb_default_slave_param_if.sv
// ---------------------------------------------------------------------------
// ahb_default_slave_param_if
// AHB-Lite slave-side signal bundle for the default slave.
//   Address phase : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADYin
//   Data phase    : HWDATA (in), HRDATA, HRESP, HREADYout (out)
// Modports:
//   slave  - seen by the default slave (bus inputs in, responses out)
//   master - seen by whatever drives the bus (decoder/mux side, testbench)
// ---------------------------------------------------------------------------
interface ahb_default_slave_param_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic [1:0]            HRESP;
   logic                  HREADYin;
   logic                  HREADYout;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
      output HRDATA, HRESP, HREADYout
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
      input  HRDATA, HRESP, HREADYout
   );
endinterface

// File: rtl/ahb_default_slave_param.sv
// ---------------------------------------------------------------------------
// ahb_default_slave_param
// AHB-Lite default slave: answers every transfer routed to unmapped address
// space. Inserts WAIT_STATES OKAY wait cycles, then either the two-cycle
// ERROR response (ERR_RESP=1) or a plain OKAY completion (ERR_RESP=0).
// Every accepted transfer is logged (address, direction, size) and counted
// on a debug/interrupt sideband.
// Ports:
//   HCLK, HRESETn - bus clock, asynchronous active-low reset
//   ahb           - AHB-Lite slave bundle (HRDATA is the constant RDATA_FILL,
//                   HRESP/HREADYout are registered; HWDATA/HBURST unused)
//   err_clr       - synchronous pulse clearing err_irq and err_count
//   err_irq       - level, set by any logged access
//   err_addr      - HADDR of the last logged access
//   err_write     - HWRITE of the last logged access
//   err_size      - HSIZE of the last logged access
//   err_count     - saturating count of logged accesses
// ---------------------------------------------------------------------------
module ahb_default_slave_param #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    WAIT_STATES = 0,
   parameter bit                    ERR_RESP    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] RDATA_FILL  = '0,
   parameter int                    CNT_WIDTH   = 8
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   ahb_default_slave_param_if.slave   ahb,
   input  logic                       err_clr,
   output logic                       err_irq,
   output logic [ADDR_WIDTH-1:0]      err_addr,
   output logic                       err_write,
   output logic [2:0]                 err_size,
   output logic [CNT_WIDTH-1:0]       err_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   // The counter is loaded with N-1 on accept so WAIT lasts exactly N cycles.
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [1:0] state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       ready_q, ready_nxt;
   logic [1:0] resp_q, resp_nxt;
   logic       final_step;
   logic       accept;

   // Only IDLE samples the address phase; WAIT and ERR1 ignore HSEL/HTRANS.
   // The final HREADYout=1 cycle is already IDLE, so a pipelined follow-on
   // transfer is accepted at the edge that ends the current data phase.
   assign accept = (state == ST_IDLE) & ahb.HSEL & ahb.HREADYin & ahb.HTRANS[1];

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      state_nxt  = state;
      cnt_nxt    = cnt;
      ready_nxt  = ready_q;
      resp_nxt   = resp_q;
      final_step = 1'b0;

      case (state)
         ST_IDLE: begin
            ready_nxt = 1'b1;
            resp_nxt  = RESP_OKAY;
            if (accept) begin
               if (WAIT_STATES > 0) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = WAIT_LOAD;
                  ready_nxt = 1'b0;
               end else begin
                  final_step = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            // Outputs hold at 0/OKAY while counting down.
            if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else             final_step = 1'b1;
         end
         ST_ERR1: begin
            // Second ERROR cycle: HREADYout rises while HRESP stays ERROR.
            state_nxt = ST_IDLE;
            ready_nxt = 1'b1;
            resp_nxt  = RESP_ERROR;
         end
         default: begin
            state_nxt = ST_IDLE;
            ready_nxt = 1'b1;
            resp_nxt  = RESP_OKAY;
         end
      endcase

      if (final_step) begin
         if (ERR_RESP) begin
            state_nxt = ST_ERR1;
            ready_nxt = 1'b0;
            resp_nxt  = RESP_ERROR;
         end else begin
            state_nxt = ST_IDLE;
            ready_nxt = 1'b1;
            resp_nxt  = RESP_OKAY;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (!HRESETn) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         ready_q <= 1'b1;
         resp_q  <= RESP_OKAY;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ready_q <= ready_nxt;
         resp_q  <= resp_nxt;
      end
   end

   // Access log and sideband. An accept coinciding with err_clr wins: the
   // count restarts at one instead of being cleared. err_clr leaves the
   // captured address/direction/size alone.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_irq   <= 1'b0;
         err_addr  <= '0;
         err_write <= 1'b0;
         err_size  <= 3'd0;
         err_count <= '0;
      end else if (accept) begin
         err_irq   <= 1'b1;
         err_addr  <= ahb.HADDR;
         err_write <= ahb.HWRITE;
         err_size  <= ahb.HSIZE;
         if (err_clr)                    err_count <= CNT_WIDTH'(1);
         else if (err_count != CNT_MAX)  err_count <= err_count + CNT_WIDTH'(1);
      end else if (err_clr) begin
         err_irq   <= 1'b0;
         err_count <= '0;
      end
   end

   assign ahb.HREADYout = ready_q;
   assign ahb.HRESP     = resp_q;
   assign ahb.HRDATA    = RDATA_FILL;

   // Write data, burst type and the BUSY/SEQ distinction carry no meaning here.
   logic unused;
   assign unused = &{1'b0, ahb.HBURST, ahb.HWDATA, ahb.HTRANS[0]};

endmodule
